// File: rtl/mpu_dispatch_fetch_if.sv
// Signal bundle between the dispatch fetcher and its scheduler, map manager,
// instruction memory and thread unit. slave = fetcher view, master = environment view.
interface mpu_dispatch_fetch_if #(
  parameter int WIDTH_ID    = 8,
  parameter int WIDTH_ADDR  = 10,
  parameter int WIDTH_INSTR = 32
);
  logic                   I_Req_Dispatch;
  logic [WIDTH_ID-1:0]    I_ThreadID;
  logic                   O_Ack_Dispatch;
  logic                   O_Busy;
  logic                   O_Req_Lookup;
  logic [WIDTH_ID-1:0]    O_ThreadID_Ld;
  logic                   I_Ack_Lookup;
  logic [WIDTH_ADDR-1:0]  I_Address;
  logic [WIDTH_ADDR-1:0]  I_Length;
  logic                   O_IMem_Re;
  logic [WIDTH_ADDR-1:0]  O_IMem_Addr;
  logic [WIDTH_INSTR-1:0] I_IMem_Data;
  logic                   O_Valid;
  logic [WIDTH_INSTR-1:0] O_Instr;
  logic                   O_Last;
  logic [WIDTH_ID-1:0]    O_ThreadID;
  logic                   I_Ready;
  logic                   O_Done;
  logic                   O_Err;

  modport slave (
    input  I_Req_Dispatch, I_ThreadID, I_Ack_Lookup, I_Address, I_Length,
           I_IMem_Data, I_Ready,
    output O_Ack_Dispatch, O_Busy, O_Req_Lookup, O_ThreadID_Ld, O_IMem_Re,
           O_IMem_Addr, O_Valid, O_Instr, O_Last, O_ThreadID, O_Done, O_Err
  );

  modport master (
    output I_Req_Dispatch, I_ThreadID, I_Ack_Lookup, I_Address, I_Length,
           I_IMem_Data, I_Ready,
    input  O_Ack_Dispatch, O_Busy, O_Req_Lookup, O_ThreadID_Ld, O_IMem_Re,
           O_IMem_Addr, O_Valid, O_Instr, O_Last, O_ThreadID, O_Done, O_Err
  );
endinterface

// File: rtl/mpu_dispatch_fetch.sv
// Dispatch-side fetcher: looks up a thread's program in the map manager and streams
// its instruction words to the thread unit through a credit-limited output FIFO.
//
// state  | meaning
// IDLE   | waiting for a dispatch request
// LOOKUP | lookup request held until the map manager acknowledges
// FETCH  | issuing instruction-memory reads while words remain
// DRAIN  | all reads issued; waiting for the last word to leave, then done
module mpu_dispatch_fetch #(
  parameter int WIDTH_ID    = 8,
  parameter int WIDTH_ADDR  = 10,
  parameter int WIDTH_INSTR = 32,
  parameter int DEPTH_FIFO  = 4
) (
  input logic                clock,
  input logic                reset,
  mpu_dispatch_fetch_if.slave bus
);
  localparam int PW = $clog2(DEPTH_FIFO);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, FETCH, DRAIN} state_t;

  state_t                  state;
  logic [WIDTH_ID-1:0]     thread_id;
  logic [WIDTH_ADDR-1:0]   addr;
  logic [WIDTH_ADDR-1:0]   remain;
  logic                    done;
  logic                    err;
  logic                    rd_valid;
  logic                    rd_last;

  logic [WIDTH_INSTR:0]    fifo_mem [DEPTH_FIFO];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;

  logic                    accept;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic                    head_last;

  assign accept    = bus.I_Req_Dispatch & (state == IDLE);
  // A read is only issued when a FIFO slot is guaranteed for its return.
  assign issue     = (state == FETCH) && (remain != '0) &&
                     ((count + CW'(rd_valid)) < CW'(DEPTH_FIFO));
  assign push      = rd_valid;
  assign pop       = (count != '0) & bus.I_Ready;
  assign head_last = fifo_mem[rd_ptr][WIDTH_INSTR];

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {rd_last, bus.I_IMem_Data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      thread_id <= '0;
      addr      <= '0;
      remain    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      rd_valid <= issue;
      rd_last  <= (remain == WIDTH_ADDR'(1));
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            thread_id <= bus.I_ThreadID;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (bus.I_Ack_Lookup) begin
            addr   <= bus.I_Address;
            remain <= bus.I_Length;
            if (bus.I_Length == '0) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= DRAIN;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (issue) begin
            addr   <= addr + WIDTH_ADDR'(1);
            remain <= remain - WIDTH_ADDR'(1);
            if (remain == WIDTH_ADDR'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Stay busy through the done cycle so no dispatch overlaps the pulse.
          if (done) begin
            state <= IDLE;
          end else if (pop && head_last) begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.O_Ack_Dispatch = accept;
  assign bus.O_Busy         = (state != IDLE);
  assign bus.O_Req_Lookup   = (state == LOOKUP);
  assign bus.O_ThreadID_Ld  = thread_id;
  assign bus.O_IMem_Re      = issue;
  assign bus.O_IMem_Addr    = addr;
  assign bus.O_Valid        = (count != '0);
  assign bus.O_Instr        = (count != '0) ? fifo_mem[rd_ptr][WIDTH_INSTR-1:0] : '0;
  assign bus.O_Last         = (count != '0) & head_last;
  assign bus.O_ThreadID     = thread_id;
  assign bus.O_Done         = done;
  assign bus.O_Err          = err;
endmodule

// File: tb/tb_mpu_dispatch_fetch.sv
// Randomized bench for mpu_dispatch_fetch: behavioural memory, map manager and
// thread-unit models with a queue-based scoreboard of the expected word stream.
module tb_mpu_dispatch_fetch;
  localparam int WI = 8;
  localparam int WA = 10;
  localparam int WD = 32;
  localparam int DEPTH_FIFO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mpu_dispatch_fetch_if #(.WIDTH_ID(WI), .WIDTH_ADDR(WA), .WIDTH_INSTR(WD)) bus ();

  mpu_dispatch_fetch #(.WIDTH_ID(WI), .WIDTH_ADDR(WA), .WIDTH_INSTR(WD), .DEPTH_FIFO(DEPTH_FIFO)) dut (
    .clock(clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [WD-1:0] imem [1024];

  // stimulus knobs
  bit          rst_drv, req_drv;
  logic [WI-1:0] id_drv;
  logic [WA-1:0] lk_addr, lk_len;
  int          ack_delay, rdy_mode, hold_cnt, lk_cnt;
  bit          lk_seen, valid_seen;
  bit          mem_pend;
  logic [WA-1:0] mem_addr;

  // reference model
  bit          m_busy, m_lookup, m_done_exp, m_err_exp, m_first_re, m_streaming;
  logic [WI-1:0] m_id;
  logic [WD:0] exp_q[$];
  logic [WA-1:0] exp_addr_q[$];
  int          issued, popped;
  bit          re_prev, prev_stall;
  logic [WD:0] prev_head;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_addr_q.delete();
    issued = 0; popped = 0;
    re_prev = 0; prev_stall = 0; prev_head = '0;
    m_busy = 0; m_lookup = 0; m_done_exp = 0; m_err_exp = 0;
    m_first_re = 0; m_streaming = 0; m_id = '0;
    lk_seen = 0; lk_cnt = 0; mem_pend = 0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ctrl"}, {bus.O_Ack_Dispatch, bus.O_Busy, bus.O_Req_Lookup, bus.O_IMem_Re,
                             bus.O_Valid, bus.O_Last, bus.O_Done, bus.O_Err}, 64'd0);
    check_eq({tag, "_ids"}, {bus.O_ThreadID_Ld, bus.O_IMem_Addr, bus.O_ThreadID}, 64'd0);
    check_eq({tag, "_instr"}, bus.O_Instr, 64'd0);
  endtask

  task automatic monitor();
    int vis;
    bit busy0, nxt_done, nxt_err, nxt_first, pop;
    logic [WD:0] e;
    logic [WA-1:0] a;
    busy0 = m_busy;
    nxt_done = 0; nxt_err = 0; nxt_first = 0;

    check_eq("ack", bus.O_Ack_Dispatch, bus.I_Req_Dispatch & ~busy0);
    check_eq("busy", bus.O_Busy, busy0);
    check_eq("req_lookup", bus.O_Req_Lookup, m_lookup);
    if (m_lookup) check_eq("id_lookup", bus.O_ThreadID_Ld, m_id);
    check_eq("done", bus.O_Done, m_done_exp);
    check_eq("err", bus.O_Err, m_err_exp);

    if (m_first_re) check_eq("first_re", bus.O_IMem_Re, 1'b1);
    else if (rdy_mode == 0 && m_streaming && exp_addr_q.size() > 0)
      check_eq("throughput", bus.O_IMem_Re, 1'b1);

    // a read issued at cycle c is visible at the output from cycle c+2
    vis = issued - popped - int'(re_prev);
    check_eq("valid", bus.O_Valid, vis > 0);

    if (bus.O_IMem_Re) begin
      if (exp_addr_q.size() == 0) check_eq("extra_read", bus.O_IMem_Re, 1'b0);
      else check_eq("rd_addr", bus.O_IMem_Addr, exp_addr_q.pop_front());
      check_eq("credit", (issued - popped) < DEPTH_FIFO, 1'b1);
      issued++;
      mem_pend = 1;
      mem_addr = bus.O_IMem_Addr;
      m_streaming = 1;
    end

    if (bus.O_Valid) begin
      check_eq("out_id", bus.O_ThreadID, m_id);
      if (prev_stall) check_eq("head_stable", {bus.O_Last, bus.O_Instr}, prev_head);
    end

    pop = bus.O_Valid & bus.I_Ready;
    if (pop) begin
      if (exp_q.size() == 0) check_eq("extra_word", bus.O_Valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        check_eq("word", {bus.O_Last, bus.O_Instr}, e);
        if (e[WD]) nxt_done = 1;
      end
      popped++;
    end
    prev_stall = bus.O_Valid & ~bus.I_Ready;
    prev_head  = {bus.O_Last, bus.O_Instr};
    re_prev    = bus.O_IMem_Re;

    if (m_done_exp) m_busy = 0;

    if (m_lookup && bus.I_Ack_Lookup) begin
      m_lookup = 0;
      if (bus.I_Length == '0) begin
        nxt_done = 1;
        nxt_err  = 1;
      end else begin
        for (int i = 0; i < int'(bus.I_Length); i++) begin
          a = bus.I_Address + WA'(i);
          exp_addr_q.push_back(a);
          exp_q.push_back({(i == int'(bus.I_Length) - 1), imem[a]});
        end
        nxt_first = 1;
      end
    end

    if (bus.I_Req_Dispatch && !busy0) begin
      m_busy   = 1;
      m_lookup = 1;
      m_id     = bus.I_ThreadID;
    end

    if (bus.I_Ack_Lookup) begin
      lk_seen = 0;
      lk_cnt  = 0;
    end else if (bus.O_Req_Lookup) begin
      lk_seen = 1;
      lk_cnt++;
    end
    if (rdy_mode == 2 && (valid_seen || bus.O_Valid)) begin
      valid_seen = 1;
      hold_cnt++;
    end

    m_done_exp = nxt_done;
    m_err_exp  = nxt_err;
    m_first_re = nxt_first;
    if (exp_addr_q.size() == 0) m_streaming = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    reset = rst_drv;
    bus.I_Req_Dispatch = req_drv;
    bus.I_ThreadID = req_drv ? id_drv : WI'($urandom);
    if (!req_drv && bus.O_Busy && $urandom_range(0, 3) == 0) bus.I_Req_Dispatch = 1'b1;
    if (lk_seen && lk_cnt > ack_delay) begin
      bus.I_Ack_Lookup = 1'b1;
      bus.I_Address    = lk_addr;
      bus.I_Length     = lk_len;
    end else begin
      bus.I_Ack_Lookup = !bus.O_Req_Lookup && ($urandom_range(0, 7) == 0);
      bus.I_Address    = WA'($urandom);
      bus.I_Length     = WA'($urandom);
    end
    case (rdy_mode)
      0:       bus.I_Ready = 1'b1;
      1:       bus.I_Ready = ($urandom_range(0, 3) != 0);
      default: bus.I_Ready = (hold_cnt >= 10);
    endcase
    bus.I_IMem_Data = mem_pend ? imem[mem_addr] : $urandom;
    mem_pend = 0;
    @(negedge clk);
    if (rst_drv) clear_model();
    else monitor();
  endtask

  task automatic run_prog(input logic [WI-1:0] id, input logic [WA-1:0] addr,
                          input logic [WA-1:0] len, input int delay, input int mode,
                          input int rst_at);
    int n, base;
    id_drv = id; lk_addr = addr; lk_len = len;
    ack_delay = delay; rdy_mode = mode;
    valid_seen = 0; hold_cnt = 0;
    base = popped;
    req_drv = 1;
    step();
    req_drv = 0;
    n = 0;
    while (m_busy && n < 3000) begin
      if (rst_at >= 0 && popped - base == rst_at) begin
        rst_drv = 1;
        step();
        rst_drv = 0;
        step();
        check_zero("midreset");
        return;
      end
      step();
      n++;
    end
    if (m_busy) begin
      check_eq("timeout", bus.O_Busy, 1'b0);
      rst_drv = 1;
      step();
      rst_drv = 0;
    end else begin
      check_eq("words_left", exp_q.size(), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = $urandom;
    reset = 1'b1;
    bus.I_Req_Dispatch = 0; bus.I_ThreadID = '0; bus.I_Ack_Lookup = 0;
    bus.I_Address = '0; bus.I_Length = '0; bus.I_IMem_Data = '0; bus.I_Ready = 0;
    req_drv = 0; id_drv = '0; lk_addr = '0; lk_len = '0;
    ack_delay = 0; rdy_mode = 0; hold_cnt = 0; valid_seen = 0;
    clear_model();

    rst_drv = 1;
    repeat (3) step();
    rst_drv = 0;
    step();
    check_zero("reset");

    run_prog(8'd5,   10'h010, 10'd3, 0, 0, -1);   // basic stream
    run_prog(8'd9,   10'h100, 10'd8, 0, 2, -1);   // backpressure
    run_prog(8'd17,  10'h3FE, 10'd4, 1, 0, -1);   // address wrap
    run_prog(8'd33,  10'h055, 10'd0, 0, 0, -1);   // zero length
    run_prog(8'd66,  10'h200, 10'd6, 5, 1, -1);   // delayed ack, busy probes
    run_prog(8'd77,  10'h300, 10'd6, 0, 1, 2);    // mid-stream reset
    run_prog(8'd78,  10'h120, 10'd5, 0, 0, -1);   // fresh dispatch after reset
    run_prog(8'd90,  10'h3C0, 10'd80, 0, 0, -1);  // long stream with wrap

    repeat (25) begin
      run_prog(WI'($urandom), WA'($urandom),
               ($urandom_range(0, 9) == 0) ? WA'(0) : WA'($urandom_range(1, 24)),
               $urandom_range(0, 6), $urandom_range(0, 2), -1);
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mpu_dispatch_fetch.md
Name: mpu_dispatch_fetch

Overview:
- Dispatch-side consumer of the MPU instruction map-table manager.
- Accepts a thread-dispatch request and performs the lookup handshake with the map manager to obtain the program base address and length.
- Streams the program's instruction words out of the instruction memory to the target thread unit, with valid/ready backpressure.
- Ends each program with a last-word flag and a done pulse.

Parameters:
- WIDTH_ID, 8, thread-ID width.
- WIDTH_ADDR, 10, instruction-memory address and length width.
- WIDTH_INSTR, 32, instruction word width.
- DEPTH_FIFO, 4, output buffer entries; power of two, minimum 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- I_Req_Dispatch  in  1  dispatch request from the scheduler.
- I_ThreadID  in  WIDTH_ID  thread to dispatch.
- O_Ack_Dispatch  out  1  request accepted.
- O_Busy  out  1  a dispatch is in progress.
- O_Req_Lookup  out  1  lookup request to the map manager.
- O_ThreadID_Ld  out  WIDTH_ID  thread ID for the lookup.
- I_Ack_Lookup  in  1  lookup acknowledge; I_Address and I_Length are valid in this cycle.
- I_Address  in  WIDTH_ADDR  program base address.
- I_Length  in  WIDTH_ADDR  program length in words.
- O_IMem_Re  out  1  instruction-memory read enable.
- O_IMem_Addr  out  WIDTH_ADDR  read address.
- I_IMem_Data  in  WIDTH_INSTR  read data, valid exactly 1 cycle after O_IMem_Re.
- O_Valid  out  1  instruction word valid.
- O_Instr  out  WIDTH_INSTR  instruction word.
- O_Last  out  1  final word of the program.
- O_ThreadID  out  WIDTH_ID  thread ID of the current stream.
- I_Ready  in  1  thread unit accepts the word.
- O_Done  out  1  one-cycle pulse when the stream is complete.
- O_Err  out  1  one-cycle pulse for a zero-length program.

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, FIFO is empty, outstanding read is cleared. A reset in any state aborts immediately; an in-flight read return is discarded.
- FSM states are IDLE, LOOKUP, FETCH, DRAIN.
- IDLE:
  - O_Ack_Dispatch = I_Req_Dispatch & (state==IDLE), combinational.
  - On accept: latch I_ThreadID into R_ThreadID and go to LOOKUP.
- LOOKUP:
  - O_Req_Lookup = 1 and O_ThreadID_Ld = R_ThreadID; O_Req_Lookup holds until I_Ack_Lookup.
  - On I_Ack_Lookup: latch R_Addr = I_Address and R_Remain = I_Length, and drop O_Req_Lookup in the next cycle.
  - If I_Length == 0: pulse O_Err and O_Done in the next cycle and return to IDLE.
  - Otherwise go to FETCH.
- FETCH:
  - O_IMem_Re = (R_Remain != 0) & (fifo_count + inflight < DEPTH_FIFO).
  - O_IMem_Addr = R_Addr.
  - On each read: R_Addr increments modulo 2^WIDTH_ADDR (wrap from max address to 0 is legal); R_Remain decrements.
  - The word tagged with R_Remain == 1 at issue carries last = 1.
  - When R_Remain reaches 0, go to DRAIN.
- DRAIN:
  - Wait until the FIFO is empty and no read is in flight.
  - Then O_Done pulses for 1 cycle, coincident with the cycle after the last-word handshake, and the FSM returns to IDLE.
  - A new dispatch is accepted no earlier than the cycle after the O_Done pulse.
- Returned data is written to the FIFO with its last flag. The FIFO never overflows because issue is credit-limited.
- Output side:
  - O_Valid = ~fifo_empty; O_Instr and O_Last come from the FIFO head; O_ThreadID = R_ThreadID.
  - A word is popped when O_Valid & I_Ready.
  - The head is held stable while O_Valid & ~I_Ready.
  - A simultaneous push and pop on a full FIFO is legal: count is unchanged.
- Throughput: 1 word/cycle with I_Ready held high.
- Latency:
  - Accept to O_Req_Lookup: 1 cycle.
  - I_Ack_Lookup to first O_IMem_Re: 1 cycle.
  - O_IMem_Re to O_Valid: 2 cycles (1 memory + 1 FIFO write).
- O_Busy = (state != IDLE).
- I_Req_Dispatch while busy: O_Ack_Dispatch stays 0 and the request is not queued.
- I_Ack_Lookup outside LOOKUP: ignored.
- Length arithmetic is unsigned WIDTH_ADDR, so the maximum program length is 2^WIDTH_ADDR-1.

Test Plan:
- Basic stream: dispatch ID=5; lookup returns Address=0x010, Length=3; I_Ready=1.
  - Required: reads at 0x010, 0x011, 0x012; three O_Valid words in order, with O_Last only on the third.
  - O_ThreadID=5 throughout; O_Done pulses once; O_Busy returns to 0.
- Backpressure: Length=8 with I_Ready=0 for 10 cycles after the first O_Valid.
  - Required: at most DEPTH_FIFO=4 words buffered plus issued; O_IMem_Re stalls; no word lost or duplicated.
  - After I_Ready=1, all 8 words arrive in address order.
- Wrap-around: Address=0x3FE, Length=4 (WIDTH_ADDR=10).
  - Required: read addresses 0x3FE, 0x3FF, 0x000, 0x001; last flag on the word from 0x001.
- Zero length: lookup returns Length=0.
  - Required: no O_IMem_Re and no O_Valid; O_Err and O_Done pulse together; FSM back in IDLE.
- Busy rejection and delayed ack:
  - Second I_Req_Dispatch during FETCH gives O_Ack_Dispatch=0.
  - Delaying I_Ack_Lookup by 5 cycles keeps O_Req_Lookup=1 and O_ThreadID_Ld stable for all 5 cycles.
- Mid-stream reset: assert reset for 1 cycle after 2 of 6 words are delivered.
  - Required: all outputs 0 the next cycle, FIFO empty, in-flight data discarded.
  - A fresh dispatch then completes normally.
